// File: rtl/multdiv_sequencer.sv
// Iterative signed multiply/divide sequencer. It owns no adder: every add is
// issued to a shared alu through the alu_* ports (opcode 0 = add). Shifts,
// muxing and carry extraction are local wiring.
module multdiv_sequencer #(
   parameter int WIDTH = 32,
   parameter int ITERS = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] alu_operandA,
   output logic [WIDTH-1:0] alu_operandB,
   output logic [4:0]       alu_opcode,
   output logic [4:0]       alu_shiftamt,
   input  logic [WIDTH-1:0] alu_result,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int CW = $clog2(ITERS);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE, S_ABS_A, S_ABS_B, S_NEG_D, S_ITER, S_SIGN, S_DONE
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_opa, r_opb, r_absb, r_negd, r_acc, r_x, r_res, r_alua, r_alub;
   logic [WIDTH-1:0] w_opa_nxt, w_opb_nxt, w_absb_nxt, w_negd_nxt, w_acc_nxt, w_x_nxt;
   logic [WIDTH-1:0] w_res_nxt, w_alua_nxt, w_alub_nxt, w_mag, w_rsh;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic             r_sign, r_div, r_ovf, r_lost, r_exc;
   logic             w_sign_nxt, w_div_nxt, w_ovf_nxt, w_lost_nxt, w_exc_nxt, w_carry;

   assign alu_operandA   = r_alua;
   assign alu_operandB   = r_alub;
   assign alu_opcode     = 5'b00000;
   assign alu_shiftamt   = 5'd0;
   assign data_result    = r_res;
   assign data_exception = r_exc;
   assign data_resultRDY = (r_state == S_DONE);
   assign busy           = (r_state != S_IDLE);

   // Unsigned carry-out of the shared add, rebuilt from the operand/result MSBs
   assign w_carry = (r_alua[WIDTH-1] & r_alub[WIDTH-1]) |
                    ((r_alua[WIDTH-1] | r_alub[WIDTH-1]) & ~alu_result[WIDTH-1]);
   // Divider partial remainder shifted left with the next dividend bit
   assign w_rsh = {r_acc[WIDTH-2:0], r_x[WIDTH-1]};

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state and next datapath values; r_x is the multiplicand or the quotient
   always_comb begin
      w_state_nxt = r_state;
      w_opa_nxt   = r_opa;
      w_opb_nxt   = r_opb;
      w_absb_nxt  = r_absb;
      w_negd_nxt  = r_negd;
      w_acc_nxt   = r_acc;
      w_x_nxt     = r_x;
      w_res_nxt   = r_res;
      w_cnt_nxt   = r_cnt;
      w_sign_nxt  = r_sign;
      w_div_nxt   = r_div;
      w_ovf_nxt   = r_ovf;
      w_lost_nxt  = r_lost;
      w_exc_nxt   = r_exc;
      case (r_state)
         S_IDLE: begin
            if (ctrl_MULT || ctrl_DIV) begin
               w_opa_nxt  = data_operandA;
               w_opb_nxt  = data_operandB;
               w_sign_nxt = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
               w_div_nxt  = ~ctrl_MULT;
               w_ovf_nxt  = 1'b0;
               w_lost_nxt = 1'b0;
               w_cnt_nxt  = '0;
               if (!ctrl_MULT && data_operandB == '0) begin
                  // Divide-by-zero short-circuits straight to DONE
                  w_state_nxt = S_DONE;
                  w_res_nxt   = '0;
                  w_exc_nxt   = 1'b1;
               end else begin
                  w_state_nxt = S_ABS_A;
               end
            end
         end
         S_ABS_A: begin
            w_x_nxt     = alu_result;
            w_state_nxt = S_ABS_B;
         end
         S_ABS_B: begin
            w_absb_nxt  = alu_result;
            w_acc_nxt   = '0;
            w_state_nxt = r_div ? S_NEG_D : S_ITER;
         end
         S_NEG_D: begin
            w_negd_nxt  = alu_result;
            w_state_nxt = S_ITER;
         end
         S_ITER: begin
            if (r_div) begin
               // Carry out means R' >= |B|: keep the difference, quotient bit 1
               if (w_carry) begin
                  w_acc_nxt = alu_result;
                  w_x_nxt   = {r_x[WIDTH-2:0], 1'b1};
               end else begin
                  w_acc_nxt = w_rsh;
                  w_x_nxt   = {r_x[WIDTH-2:0], 1'b0};
               end
            end else begin
               w_acc_nxt  = alu_result;
               w_x_nxt    = {r_x[WIDTH-2:0], 1'b0};
               w_lost_nxt = r_lost | r_x[WIDTH-1];
               w_ovf_nxt  = r_ovf | w_carry | (r_absb[r_cnt] & r_lost);
            end
            w_cnt_nxt = r_cnt + CW'(1);
            if (r_cnt == CW'(ITERS-1)) w_state_nxt = S_SIGN;
         end
         S_SIGN: begin
            w_res_nxt = alu_result;
            // Magnitude 2^31 is representable only as a negative product
            w_exc_nxt = r_div ? 1'b0 :
                        (r_ovf | (r_acc[WIDTH-1] & ~(r_sign & (r_acc == MIN_NEG))));
            w_state_nxt = S_DONE;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Alu operands for the state being entered, so they sit in flops during it
   always_comb begin
      w_alua_nxt = '0;
      w_alub_nxt = '0;
      w_mag      = w_div_nxt ? w_x_nxt : w_acc_nxt;
      case (w_state_nxt)
         S_ABS_A: begin
            w_alua_nxt = w_opa_nxt[WIDTH-1] ? ~w_opa_nxt : w_opa_nxt;
            w_alub_nxt = WIDTH'(w_opa_nxt[WIDTH-1]);
         end
         S_ABS_B: begin
            w_alua_nxt = w_opb_nxt[WIDTH-1] ? ~w_opb_nxt : w_opb_nxt;
            w_alub_nxt = WIDTH'(w_opb_nxt[WIDTH-1]);
         end
         S_NEG_D: begin
            w_alua_nxt = ~w_absb_nxt;
            w_alub_nxt = WIDTH'(1);
         end
         S_ITER: begin
            if (w_div_nxt) begin
               w_alua_nxt = {w_acc_nxt[WIDTH-2:0], w_x_nxt[WIDTH-1]};
               w_alub_nxt = w_negd_nxt;
            end else begin
               w_alua_nxt = w_acc_nxt;
               w_alub_nxt = w_absb_nxt[w_cnt_nxt] ? w_x_nxt : '0;
            end
         end
         S_SIGN: begin
            w_alua_nxt = w_sign_nxt ? ~w_mag : w_mag;
            w_alub_nxt = WIDTH'(w_sign_nxt);
         end
         default: begin
            w_alua_nxt = '0;
            w_alub_nxt = '0;
         end
      endcase
   end

   // Datapath registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_opa  <= '0;
         r_opb  <= '0;
         r_absb <= '0;
         r_negd <= '0;
         r_acc  <= '0;
         r_x    <= '0;
         r_res  <= '0;
         r_alua <= '0;
         r_alub <= '0;
         r_cnt  <= '0;
         r_sign <= 1'b0;
         r_div  <= 1'b0;
         r_ovf  <= 1'b0;
         r_lost <= 1'b0;
         r_exc  <= 1'b0;
      end else begin
         r_opa  <= w_opa_nxt;
         r_opb  <= w_opb_nxt;
         r_absb <= w_absb_nxt;
         r_negd <= w_negd_nxt;
         r_acc  <= w_acc_nxt;
         r_x    <= w_x_nxt;
         r_res  <= w_res_nxt;
         r_alua <= w_alua_nxt;
         r_alub <= w_alub_nxt;
         r_cnt  <= w_cnt_nxt;
         r_sign <= w_sign_nxt;
         r_div  <= w_div_nxt;
         r_ovf  <= w_ovf_nxt;
         r_lost <= w_lost_nxt;
         r_exc  <= w_exc_nxt;
      end
   end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer with a behavioural shared alu and a
// result scoreboard keyed on start cycle.
module tb_multdiv_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
   logic [31:0] data_operandA = '0, data_operandB = '0;
   logic [31:0] alu_operandA, alu_operandB, alu_result, data_result;
   logic [4:0]  alu_opcode, alu_shiftamt;
   logic        data_exception, data_resultRDY, busy;

   typedef struct {
      logic [31:0] res;
      logic        exc;
      int          t0;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   done_cnt = 0;
   logic prev_rdy = 1'b0;

   multdiv_sequencer dut (
      .clock(clock), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
      .data_operandA(data_operandA), .data_operandB(data_operandB),
      .alu_operandA(alu_operandA), .alu_operandB(alu_operandB),
      .alu_opcode(alu_opcode), .alu_shiftamt(alu_shiftamt), .alu_result(alu_result),
      .data_result(data_result), .data_exception(data_exception),
      .data_resultRDY(data_resultRDY), .busy(busy)
   );

   // Shared alu: add only when asked for opcode 0 / shift 0
   assign alu_result = (alu_opcode == 5'd0 && alu_shiftamt == 5'd0) ?
                       alu_operandA + alu_operandB : alu_operandA - alu_operandB;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   function automatic exp_t model(input bit m, input logic [31:0] a, input logic [31:0] b,
                                  input int t0);
      exp_t   e;
      longint p;
      e.t0 = t0;
      if (m) begin
         p     = longint'($signed(a)) * longint'($signed(b));
         e.res = p[31:0];
         e.exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
         e.lat = 36;
      end else if (b == 32'd0) begin
         e.res = '0;
         e.exc = 1'b1;
         e.lat = 1;
      end else begin
         p     = longint'($signed(a)) / longint'($signed(b));
         e.res = p[31:0];
         e.exc = 1'b0;
         e.lat = 37;
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Per-cycle invariants and scoreboard pop on result
   always @(negedge clock) begin
      if (!reset) begin
         n_checks++;
         assert (alu_opcode === 5'd0 && alu_shiftamt === 5'd0) else begin
            n_fail++;
            $error("FAIL alu_ctrl got=%0h/%0h exp=0/0", alu_opcode, alu_shiftamt);
         end
         if (data_resultRDY === 1'b1) begin
            exp_t e;
            n_checks++;
            assert (prev_rdy !== 1'b1) else begin
               n_fail++;
               $error("FAIL rdy_width got=2cycles exp=1cycle");
            end
            n_checks++;
            assert (sb.size() != 0) else begin
               n_fail++;
               $error("FAIL unexpected_rdy got=rdy exp=none cyc=%0d", cyc);
            end
            if (sb.size() != 0) begin
               e = sb.pop_front();
               n_checks++;
               assert (data_result === e.res) else begin
                  n_fail++;
                  $error("FAIL result got=%0h exp=%0h", data_result, e.res);
               end
               n_checks++;
               assert (data_exception === e.exc) else begin
                  n_fail++;
                  $error("FAIL exception got=%0b exp=%0b", data_exception, e.exc);
               end
               n_checks++;
               assert (cyc - e.t0 === e.lat) else begin
                  n_fail++;
                  $error("FAIL latency got=%0d exp=%0d", cyc - e.t0, e.lat);
               end
            end
            done_cnt++;
         end
      end
      prev_rdy <= data_resultRDY;
   end

   // Drive one start cycle; returns at the negedge of cycle T+1
   task automatic go(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
      if (m || d) sb.push_back(model(m, a, b, cyc));
      @(negedge clock);
      ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
      data_operandA = $urandom; data_operandB = $urandom;
   endtask

   task automatic wait_done(input int n0);
      bit seen = 0;
      for (int i = 0; i < 80 && !seen; i++) begin
         @(negedge clock); #1;
         if (done_cnt > n0) seen = 1;
      end
      n_checks++;
      assert (seen) else begin
         n_fail++;
         $error("FAIL timeout got=no_rdy exp=rdy");
      end
   endtask

   task automatic run(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
      int n0 = done_cnt;
      go(m, d, a, b);
      wait_done(n0);
   endtask

   initial begin
      int  n0;
      bit  bad;
      // Reset state
      repeat (2) @(negedge clock);
      chk("rst_result", data_result, 32'd0);
      chk("rst_exc", {31'd0, data_exception}, 32'd0);
      chk("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_aluA", alu_operandA, 32'd0);
      chk("rst_aluB", alu_operandB, 32'd0);
      reset = 1'b0;

      // 6*7 with busy window and RDY at T+36
      n0 = done_cnt;
      go(1, 0, 32'd6, 32'd7);
      bad = 0;
      for (int i = 0; i < 35; i++) begin
         if (busy !== 1'b1 || data_resultRDY !== 1'b0) bad = 1;
         @(negedge clock);
      end
      chk("busy_window", {31'd0, bad}, 32'd0);
      #1;
      chk("mult_rdy_T36", {31'd0, data_resultRDY}, 32'd1);
      @(negedge clock); #1;
      chk("idle_after_done", {31'd0, busy}, 32'd0);
      chk("idle_aluA", alu_operandA, 32'd0);
      chk("done_count", done_cnt, n0 + 1);

      // Divides including divide-by-zero followed by a normal op
      run(0, 1, 32'hFFFF_FFF8, 32'd3);
      run(0, 1, 32'd5, 32'd0);
      chk("dz_hold_exc", {31'd0, data_exception}, 32'd1);
      run(1, 0, 32'd12, 32'd11);
      run(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
      run(0, 1, 32'd7, 32'hFFFF_FFFE);
      run(0, 1, 32'd1000, 32'd1000);
      run(0, 1, 32'd3, 32'h8000_0000);

      // Multiply overflow boundaries
      run(1, 0, 32'd65536, 32'd65536);
      run(1, 0, 32'h8000_0000, 32'd1);
      run(1, 0, 32'hFFFF_0000, 32'd32768);
      run(1, 0, 32'd65536, 32'd32768);
      run(1, 0, 32'h8000_0000, 32'hFFFF_FFFF);
      run(1, 0, 32'h1234_5678, 32'hFFFF_FEDC);

      // Both ctrl high: MULT wins; a DIV pulse mid-operation is ignored
      n0 = done_cnt;
      go(1, 1, 32'd9, 32'd3);
      repeat (9) @(negedge clock);
      ctrl_DIV = 1'b1; data_operandA = 32'd100; data_operandB = 32'd0;
      @(negedge clock);
      ctrl_DIV = 1'b0;
      wait_done(n0);
      repeat (5) @(negedge clock);
      chk("no_extra_op", done_cnt, n0 + 1);
      chk("idle_after_pulse", {31'd0, busy}, 32'd0);

      // Reset during ITER 10
      go(1, 0, 32'd100, 32'd7);
      repeat (12) @(negedge clock);
      n0 = done_cnt;
      reset = 1'b1;
      #1;
      sb.delete();
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_result", data_result, 32'd0);
      chk("midrst_aluA", alu_operandA, 32'd0);
      chk("midrst_aluB", alu_operandB, 32'd0);
      chk("midrst_rdy", {31'd0, data_resultRDY}, 32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (40) @(negedge clock);
      chk("midrst_no_rdy", done_cnt, n0);
      run(1, 0, 32'd3, 32'hFFFF_FFFB);

      // A few random operations
      for (int i = 0; i < 4; i++) run(i[0], ~i[0], $urandom, $urandom_range(1, 1000));

      repeat (3) @(negedge clock);
      chk("sb_empty", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
